// File: rtl/rej_sample_ntt.sv
// ============================================================================
// Module   : rej_sample_ntt
// Purpose  : Kyber SampleNTT rejection sampler; turns SHAKE128 rate blocks
//            into one polynomial of N coefficients in [0, Q).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rej_sample_ntt #(
  parameter int R = 1344,
  parameter int Q = 3329,
  parameter int N = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [R-1:0] blk_in,
  input  logic         blk_valid,
  output logic         blk_ready,
  output logic [11:0]  coef_out,
  output logic [7:0]   coef_idx,
  output logic         coef_valid,
  input  logic         coef_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [11:0] c_q        = 12'(Q);
  localparam logic [6:0]  c_last_k   = 7'(R / 12 - 1);
  localparam logic [8:0]  c_last_cnt = 9'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_BLK = 2'd1,
    S_SCAN     = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [R-1:0]   r_buf;
  logic [6:0]     r_k;
  logic [8:0]     r_cnt;

  logic [11:0]    w_cand;
  logic           w_accept;
  logic           w_last_k;
  logic           w_load;
  logic           w_shift;
  logic           w_inc_cnt;
  logic           w_clr_cnt;

  assign w_cand   = r_buf[11:0];
  assign w_accept = (w_cand < c_q);
  assign w_last_k = (r_k == c_last_k);
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    blk_ready  = 1'b0;
    coef_valid = 1'b0;
    coef_out   = 12'd0;
    coef_idx   = 8'd0;
    done       = 1'b0;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_inc_cnt  = 1'b0;
    w_clr_cnt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clr_cnt = 1'b1;
          w_next    = S_WAIT_BLK;
        end
      end
      S_WAIT_BLK: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          w_load = 1'b1;
          w_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_accept) begin
          // Hold the candidate and its index steady until the consumer takes it.
          coef_valid = 1'b1;
          coef_out   = w_cand;
          coef_idx   = r_cnt[7:0];
          if (coef_ready) begin
            w_shift   = 1'b1;
            w_inc_cnt = 1'b1;
            if (r_cnt == c_last_cnt) begin
              w_next = S_DONE;
            end else if (w_last_k) begin
              w_next = S_WAIT_BLK;
            end
          end
        end else begin
          w_shift = 1'b1;
          if (w_last_k) begin
            w_next = S_WAIT_BLK;
          end
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf <= '0;
      r_k   <= 7'd0;
      r_cnt <= 9'd0;
    end else begin
      if (w_load) begin
        r_buf <= blk_in;
        r_k   <= 7'd0;
      end else if (w_shift) begin
        r_buf <= {12'd0, r_buf[R-1:12]};
        r_k   <= r_k + 7'd1;
      end
      if (w_clr_cnt) begin
        r_cnt <= 9'd0;
      end else if (w_inc_cnt) begin
        r_cnt <= r_cnt + 9'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rej_sample_ntt.sv
// ============================================================================
// Module   : tb_rej_sample_ntt
// Purpose  : Directed and model-checked stimulus for rej_sample_ntt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rej_sample_ntt;

  localparam int R  = 1344;
  localparam int Q  = 3329;
  localparam int N  = 256;
  localparam int KC = R / 12;
  localparam int NB = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [R-1:0] blk_in;
  logic         blk_valid;
  logic         blk_ready;
  logic [11:0]  coef_out;
  logic [7:0]   coef_idx;
  logic         coef_valid;
  logic         coef_ready;
  logic         busy;
  logic         done;

  rej_sample_ntt #(.R(R), .Q(Q), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .blk_in     (blk_in),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .coef_out   (coef_out),
    .coef_idx   (coef_idx),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] cand;
    bit          acc;
  } vec_t;

  vec_t         tbl[8];
  logic [R-1:0] blk_arr[NB];
  logic [11:0]  exp_coef[N];
  int           exp_blocks;
  int           n_vec  = 0;
  int           n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_blk_ready"}, blk_ready, 0);
    chk({nm, "_coef_valid"}, coef_valid, 0);
    chk({nm, "_coef_out"}, coef_out, 0);
    chk({nm, "_coef_idx"}, coef_idx, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  // Software SampleNTT over the byte-triple (d1, d2) form.
  task automatic build_model();
    int c;
    logic [7:0] b0, b1, b2;
    int d1, d2;
    c = 0;
    exp_blocks = 0;
    for (int b = 0; b < NB; b++) begin
      if (c < N) begin
        exp_blocks = b + 1;
        for (int t = 0; t < R / 24; t++) begin
          b0 = blk_arr[b][24*t +: 8];
          b1 = blk_arr[b][24*t+8 +: 8];
          b2 = blk_arr[b][24*t+16 +: 8];
          d1 = int'(b0) + 256 * (int'(b1) % 16);
          d2 = int'(b1) / 16 + 16 * int'(b2);
          if (d1 < Q && c < N) begin exp_coef[c] = 12'(d1); c++; end
          if (d2 < Q && c < N) begin exp_coef[c] = 12'(d2); c++; end
        end
      end
    end
  endtask

  task automatic run_poly(input int ready_pct, input int abort_at, input bit start_mid);
    int cnt;
    int bi;
    cnt = 0;
    bi  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("blk_ready_after_start", blk_ready, 1);
    for (int cyc = 0; cyc < 5000 && cnt < N; cyc++) begin
      if (abort_at >= 0 && cnt == abort_at && coef_valid) begin
        rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        blk_valid  = 1'b0;
        coef_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("abort_no_done", done, 0);
        chk("abort_idle", busy, 0);
        return;
      end
      if (coef_valid) begin
        if (cnt >= N) begin
          chk("extra_coef", 1, 0);
        end else begin
          chk("coef_out", coef_out, exp_coef[cnt]);
          chk("coef_idx", coef_idx, cnt[7:0]);
        end
        coef_ready = ($urandom_range(99) < ready_pct);
        if (coef_ready) cnt++;
      end else begin
        coef_ready = 1'($urandom_range(1));
      end
      // blk_valid stays high so any consumption outside WAIT_BLK shows up.
      blk_valid = (bi < NB);
      blk_in    = blk_arr[bi % NB];
      if (blk_ready && bi < NB) bi++;
      start = start_mid && (cnt == 50);
      tick();
    end
    start      = 1'b0;
    blk_valid  = 1'b0;
    coef_ready = 1'b0;
    chk("coef_count_reached", cnt, N);
    if (cnt == N) begin
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      chk("done_no_valid", coef_valid, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
      tick();
      chk("start_with_done_ignored", busy, 0);
      chk("blocks_consumed", bi, exp_blocks);
    end
  endtask

  initial begin
    logic [R-1:0] blk;
    int cnt;
    tbl[0] = '{12'd3328, 1'b1};
    tbl[1] = '{12'd3329, 1'b0};
    tbl[2] = '{12'd4095, 1'b0};
    tbl[3] = '{12'd0,    1'b1};
    tbl[4] = '{12'd1,    1'b1};
    tbl[5] = '{12'd3330, 1'b0};
    tbl[6] = '{12'd2048, 1'b1};
    tbl[7] = '{12'd4094, 1'b0};

    rst = 1'b1; start = 1'b0; blk_in = '0; blk_valid = 1'b0; coef_ready = 1'b1;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Boundary-value table block, no backpressure.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wait_blk_ready", blk_ready, 1);
    chk("wait_busy", busy, 1);
    for (int k = 0; k < KC; k++) blk[12*k +: 12] = tbl[k % 8].cand;
    blk_in = blk; blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < KC; k++) begin
      chk("tbl_valid", coef_valid, tbl[k % 8].acc);
      if (tbl[k % 8].acc) begin
        chk("tbl_out", coef_out, tbl[k % 8].cand);
        chk("tbl_idx", coef_idx, cnt);
        cnt++;
      end else begin
        chk("tbl_out_zero", coef_out, 0);
      end
      chk("tbl_no_blk_ready", blk_ready, 0);
      tick();
    end
    chk("tbl_blk_ready_again", blk_ready, 1);

    // All-ones block: nothing accepted, blk_ready back after 113 cycles.
    blk_in = '1; blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int k = 0; k < KC; k++) begin
      chk("ones_valid", coef_valid, 0);
      chk("ones_blk_ready", blk_ready, 0);
      tick();
    end
    chk("ones_blk_ready_113", blk_ready, 1);

    // Accepted count survives the empty block.
    blk_in = blk; blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    chk("cnt_kept_idx", coef_idx, cnt);
    chk("cnt_kept_out", coef_out, 3328);
    rst = 1'b1;
    #1;
    chk_reset_outputs("tbl_abort");
    tick();
    rst = 1'b0;
    tick();

    for (int b = 0; b < NB; b++) blk_arr[b] = '0;
    build_model();
    chk("zero_model_blocks", exp_blocks, 3);
    run_poly(100, -1, 1'b0);

    for (int b = 0; b < NB; b++)
      for (int w = 0; w < R / 32; w++) blk_arr[b][32*w +: 32] = $urandom;
    build_model();
    run_poly(100, -1, 1'b1);
    run_poly(50, -1, 1'b0);
    run_poly(100, 100, 1'b0);
    run_poly(70, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rej_sample_ntt.md
# rej_sample_ntt

Kyber rejection sampler (FIPS 203 SampleNTT) that consumes SHAKE128 squeeze blocks and emits one polynomial of 256 coefficients in [0, Q).
- Sits directly downstream of the SHAKE128 sponge and upstream of matrix-Â storage and the NTT-domain multiplier.
- Splits each R-bit rate block into 12-bit candidates, keeps those below Q, and requests further blocks until 256 coefficients have been delivered.

## Interface
Parameters:
- R, 1344: rate block width in bits; yields R/12 = 112 candidates per block.
- Q, 3329: modulus; a candidate is accepted iff it is < Q.
- N, 256: coefficients per polynomial.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new polynomial; ignored unless in IDLE.
- blk_in  in  R  squeeze block; bit 0 is bit 0 of byte 0.
- blk_valid  in  1  blk_in holds a valid block.
- blk_ready  out  1  sampler will accept a block this cycle.
- coef_out  out  12  current accepted coefficient.
- coef_idx  out  8  index 0..255 of coef_out.
- coef_valid  out  1  coef_out/coef_idx valid.
- coef_ready  in  1  downstream accepts the coefficient.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse once coefficient 255 has been accepted.

## Operation
- Candidate k (0 ≤ k < R/12) of a block is blk_in[12k+11:12k]. This equals d1 = b0 + 256·(b1 mod 16) and d2 = ⌊b1/16⌋ + 16·b2 for each byte triple.
- Candidates are evaluated in ascending k order.
- Internal state:
  - R-bit buffer `buf`, shifted right 12 bits per consumed candidate.
  - Candidate counter `k`, 7 bits.
  - Accepted counter `cnt`, 9 bits.
- FSM states:
  - IDLE: blk_ready=0, coef_valid=0. On start, go to WAIT_BLK and set cnt=0.
  - WAIT_BLK: blk_ready=1. On blk_valid, load buf←blk_in, set k=0, go to SCAN.
  - SCAN: cand = buf[11:0].
    - If cand ≥ Q: reject; shift buf, increment k.
    - If cand < Q: coef_valid=1, coef_out=cand, coef_idx=cnt[7:0]. Hold buf, k and cnt until coef_ready. On the handshake, shift buf, increment k and cnt.
    - If the handshake brings cnt to N: go to DONE. Unconsumed candidates are discarded.
    - Else if the consumed candidate was k = R/12−1: go to WAIT_BLK.
  - DONE: done=1 for exactly one cycle, then IDLE.
- coef_out and coef_idx are driven only while coef_valid=1; otherwise they hold 0.
- Once asserted, coef_valid stays high with stable data until coef_ready.
- The sampler never drives blk_ready outside WAIT_BLK.

## Timing
- Reset values: blk_ready=0, coef_valid=0, coef_out=0, coef_idx=0, busy=0, done=0. State returns to IDLE, and buf, k and cnt clear.
- Reset mid-operation abandons the polynomial immediately. No done pulse follows; start is required again.
- start → blk_ready high on the next cycle.
- Block accepted on edge t (blk_valid & blk_ready) → candidate 0 evaluated during cycle t+1. If it is accepted, coef_valid is high in t+1.
- Each candidate takes exactly one cycle when rejected, or when accepted with coef_ready=1. Backpressure adds stall cycles one for one.
- Full throughput: 1 block in, then ≤112 SCAN cycles, then 1 WAIT_BLK cycle minimum before the next block.
- Last-candidate handshake on edge t → blk_ready high in t+1.
- Final handshake (cnt becomes 256) on edge t → done high in t+1, then IDLE in t+2. busy is low from t+2 onward.
- start asserted during busy: no effect.
- start and done in the same cycle: start is ignored.
- blk_valid outside WAIT_BLK: ignored; the block is not consumed.

## Test plan
- All-zero blocks, coef_ready tied 1 → 256 coefficients of value 0 with indices 0..255. Exactly 3 blocks consumed (112+112+32). done pulses one cycle after index 255. Block 3's remaining 80 candidates are discarded.
- Boundary values: block candidates alternating 3328, 3329, 4095, 0 → only 3328 and 0 emitted, in order. Rejected candidates emit nothing and each costs one cycle.
- All-ones block (every candidate 0xFFF) → zero coef_valid cycles. blk_ready reasserts exactly 113 cycles after the block handshake. cnt unchanged.
- Random blocks checked against a software SampleNTT model (byte-triple d1/d2 form) → identical 256-coefficient sequence and identical block count.
- Random coef_ready backpressure (50%) → coef_out/coef_idx stable while coef_valid & !coef_ready. No loss or duplication. Same sequence as the no-stall run.
- rst asserted mid-SCAN at cnt=100 → all outputs at reset values within the same cycle. A following start yields coef_idx restarting at 0. A start pulse during busy has no effect.
